// File: rtl/clk_sched_pkg.sv
// Shared definitions for the divided-clock scheduler: config FSM encoding,
// default channel count / counter width, and the channel-index width helper.
package clk_sched_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_t;

  // A single channel still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: wrapping counter with registered tick strobe and
// square-wave enable, divisor load port and a boundary flag for the config FSM.
module clk_div_chan
  import clk_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_div,
  input  logic         sync,
  output logic         tick,
  output logic         clk_out,
  output logic         boundary
);

  logic [W-1:0] div;
  logic [W-1:0] cnt;
  logic [W-1:0] div_n;
  logic [W-1:0] cnt_n;
  logic [W-1:0] last;
  logic         wrap;

  assign last     = div - W'(1);
  assign wrap     = (div != '0) && (cnt == last);
  assign boundary = (div == '0) || wrap;

  always_comb begin
    div_n = div;
    cnt_n = cnt;
    if (ld) begin
      div_n = ld_div;
      cnt_n = '0;
    end else if ((div == '0) || sync || wrap) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + W'(1);
    end
  end

  // Outputs are computed from next-state values so they line up with cnt.
  // A sync restart never strobes in its first cycle, even for D=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      div     <= div_n;
      cnt     <= cnt_n;
      tick    <= (div_n != '0) && (cnt_n == (div_n - W'(1))) && !sync;
      clk_out <= (cnt_n < (div_n >> 1));
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// N-channel runtime-programmable clock-enable scheduler; divisor updates are
// queued in a single pending slot and applied only at the target's boundary.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | slot free, cfg_ready=1, accepts a new divisor
//  ST_PEND  | slot full, waiting for target's tick, D==0, or sync
//  ST_APPLY | one cycle: pending divisor loaded, target counter cleared
module clk_div_sched
  import clk_sched_pkg::*;
#(
  parameter int  N  = N_DEF,
  parameter int  W  = W_DEF,
  localparam int CW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic          sync,
  output logic [N-1:0]  tick_out,
  output logic [N-1:0]  clk_out,
  output logic          busy
);

  localparam logic [CW:0] N_CH = (CW + 1)'(N);

  cfg_state_t    state;
  logic [CW-1:0] pend_ch;
  logic [W-1:0]  pend_div;
  logic [N-1:0]  bnd;
  logic [N-1:0]  ld;
  logic          xfer;
  logic          ch_ok;
  logic          pend_bnd;

  assign xfer     = cfg_valid && cfg_ready;
  assign ch_ok    = ({1'b0, cfg_ch} < N_CH);
  assign pend_bnd = bnd[pend_ch];

  for (genvar i = 0; i < N; i++) begin : g_chan
    // A sync during PEND loads in the same edge as the alignment.
    assign ld[i] = (pend_ch == CW'(i)) &&
                   ((state == ST_APPLY) || ((state == ST_PEND) && sync));

    clk_div_chan #(.W(W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld[i]),
      .ld_div   (pend_div),
      .sync     (sync),
      .tick     (tick_out[i]),
      .clk_out  (clk_out[i]),
      .boundary (bnd[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pend_ch   <= '0;
      pend_div  <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer && ch_ok) begin
            pend_ch   <= cfg_ch;
            pend_div  <= cfg_div;
            state     <= ST_PEND;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_PEND: begin
          // Already applied alongside the sync, so skip the APPLY cycle.
          if (sync) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (pend_bnd) begin
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: phase-based reference model checked
// every cycle, a table of divisor vectors, and directed multi-cycle scenarios.
`timescale 1ns/1ps
module tb_clk_div_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [19:0] cfg_div = '0;
  logic        sync = 1'b0;
  logic [3:0]  tick_out;
  logic [3:0]  clk_out;
  logic        busy;

  // Second instance with N=3 so an out-of-range channel index is expressible.
  logic        v3 = 1'b0;
  logic [1:0]  ch3 = '0;
  logic [7:0]  div3 = '0;
  logic        ready3;
  logic        busy3;
  logic [2:0]  tick3;
  logic [2:0]  clk3;

  clk_div_sched #(.N(4), .W(20)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync(sync),
    .tick_out(tick_out), .clk_out(clk_out), .busy(busy));

  clk_div_sched #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .cfg_valid(v3), .cfg_ready(ready3),
    .cfg_ch(ch3), .cfg_div(div3), .sync(sync),
    .tick_out(tick3), .clk_out(clk3), .busy(busy3));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each channel is a divisor plus the cycle its period began.
  int     m_d[4];
  longint m_t0[4];
  int     m_mode;   // 0 idle, 1 waiting for boundary, 2 applying
  int     m_pch;
  int     m_pdiv;
  bit     m_sync_prev;
  longint m_cyc = 0;

  function automatic bit m_tick(input int i);
    longint ph;
    if (m_d[i] == 0) return 1'b0;
    ph = (m_cyc - m_t0[i]) % m_d[i];
    return (ph == m_d[i] - 1) && !m_sync_prev;
  endfunction

  function automatic bit m_clk(input int i);
    longint ph;
    if (m_d[i] == 0) return 1'b0;
    ph = (m_cyc - m_t0[i]) % m_d[i];
    return ph < (m_d[i] / 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_d[i] = 0; m_t0[i] = 0; end
    m_mode = 0; m_pch = 0; m_pdiv = 0; m_sync_prev = 1'b0;
  endtask

  task automatic m_adv(input bit v, input int ch, input int dv, input bit s);
    bit pbnd;
    int pd;
    pd   = m_d[m_pch];
    pbnd = (pd == 0) || (((m_cyc - m_t0[m_pch]) % pd) == pd - 1);
    for (int i = 0; i < 4; i++) if (s && m_d[i] != 0) m_t0[i] = m_cyc + 1;
    case (m_mode)
      0: if (v && ch < 4) begin m_pch = ch; m_pdiv = dv; m_mode = 1; end
      1: if (s) begin
           m_d[m_pch] = m_pdiv; m_t0[m_pch] = m_cyc + 1; m_mode = 0;
         end else if (pbnd) m_mode = 2;
      default: begin m_d[m_pch] = m_pdiv; m_t0[m_pch] = m_cyc + 1; m_mode = 0; end
    endcase
    m_sync_prev = s;
    m_cyc++;
  endtask

  logic [3:0] s_tick, s_clk;
  logic       s_ready, s_busy;
  longint     last_t[4];
  int         gap[4];

  task automatic step();
    logic [3:0] et, ec;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin et[i] = m_tick(i); ec[i] = m_clk(i); end
    s_tick = tick_out; s_clk = clk_out; s_ready = cfg_ready; s_busy = busy;
    chk("tick_out", 32'(tick_out), 32'(et));
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == 0));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    for (int i = 0; i < 4; i++)
      if (s_tick[i]) begin gap[i] = int'(m_cyc - last_t[i]); last_t[i] = m_cyc; end
    m_adv(cfg_valid, int'(cfg_ch), int'(cfg_div), sync);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_valid = 1'b0; sync = 1'b0; v3 = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick_out), 32'h0);
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
  endtask

  task automatic prog(input int ch, input int dv, output int low);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 20'(dv);
    step();
    cfg_valid = 1'b0;
    low = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (s_ready) break;
      low++;
    end
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin step(); n++; end while (!s_tick[ch] && n < 300);
  endtask

  typedef struct { int ch; int dv; int low; int first; int per; int hi; } vec_t;
  vec_t tbl[5];

  initial begin
    int low, n, hi, first, cnt, k, k0, k1;
    tbl[0] = '{0, 4, 2, 4, 4, 2};
    tbl[1] = '{1, 1, 2, 1, 1, 0};
    tbl[2] = '{2, 5, 2, 5, 5, 2};
    tbl[3] = '{3, 2, 2, 2, 2, 1};
    tbl[4] = '{0, 7, 2, 7, 7, 3};
    for (int i = 0; i < 4; i++) begin last_t[i] = 0; gap[i] = 0; end

    // Reset state, then a quiet idle stretch.
    do_reset();
    cnt = 0;
    repeat (100) begin step(); if (s_tick != 0) cnt++; end
    chk("idle_no_ticks", 32'(cnt), 32'h0);

    // Table: divisor -> handshake latency, first tick, period, high cycles.
    foreach (tbl[t]) begin
      do_reset();
      prog(tbl[t].ch, tbl[t].dv, low);
      chk("tbl_ready_low", 32'(low), 32'(tbl[t].low));
      first = 1;
      if (!s_tick[tbl[t].ch]) begin wait_tick(tbl[t].ch, n); first = 1 + n; end
      chk("tbl_first_tick", 32'(first), 32'(tbl[t].first));
      n = 0; hi = 0;
      do begin step(); n++; hi += int'(s_clk[tbl[t].ch]); end
        while (!s_tick[tbl[t].ch] && n < 300);
      chk("tbl_period", 32'(n), 32'(tbl[t].per));
      chk("tbl_high", 32'(hi), 32'(tbl[t].hi));
    end

    // Reprogram ch1 from 10 to 3 while its counter sits at 3.
    do_reset();
    prog(1, 10, low);
    wait_tick(1, n);
    repeat (3) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 20'd3;
    step();
    cfg_valid = 1'b0;
    cnt = 0;
    for (k = 0; k < 300; k++) begin step(); if (!s_busy) break; cnt++; end
    chk("reprog_busy", 32'(cnt), 32'd7);
    wait_tick(1, n);
    chk("reprog_gap", 32'(gap[1]), 32'd4);
    wait_tick(1, n);
    chk("reprog_new1", 32'(n), 32'd3);
    wait_tick(1, n);
    chk("reprog_new2", 32'(n), 32'd3);

    // sync aligns ch0=4 and ch1=6; they next coincide 12 cycles later.
    do_reset();
    prog(0, 4, low);
    prog(1, 6, low);
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    k0 = 0; k1 = 0;
    for (k = 1; k < 60; k++) begin
      step();
      if (s_tick[0] && k0 == 0) k0 = k;
      if (s_tick[1] && k1 == 0) k1 = k;
      if (s_tick[0] && s_tick[1]) break;
    end
    chk("sync_first0", 32'(k0), 32'd4);
    chk("sync_first1", 32'(k1), 32'd6);
    chk("sync_coincide", 32'(k), 32'd12);

    // Out-of-range channel dropped; in-range one accepted.
    do_reset();
    v3 = 1'b1; ch3 = 2'd3; div3 = 8'd5;
    step();
    v3 = 1'b0;
    chk("oor_ready", 32'(ready3), 32'h1);
    chk("oor_busy", 32'(busy3), 32'h0);
    repeat (10) step();
    chk("oor_ticks", 32'(tick3), 32'h0);
    v3 = 1'b1; ch3 = 2'd2; div3 = 8'd3;
    step();
    v3 = 1'b0;
    chk("inr_ready", 32'(ready3), 32'h0);
    chk("inr_busy", 32'(busy3), 32'h1);

    // Divisor 0 on a running channel silences it after its boundary.
    prog(2, 5, low);
    wait_tick(2, n);
    prog(2, 0, low);
    cnt = 0;
    repeat (20) begin step(); cnt += int'(s_tick[2]) + int'(s_clk[2]); end
    chk("disable_quiet", 32'(cnt), 32'h0);

    // Reset while an update is pending.
    do_reset();
    prog(0, 8, low);
    repeat (2) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 20'd3;
    step();
    cfg_valid = 1'b0;
    step();
    chk("pend_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_tick", 32'(tick_out), 32'h0);
    chk("async_clk", 32'(clk_out), 32'h0);
    chk("async_ready", 32'(cfg_ready), 32'h1);
    chk("async_busy", 32'(busy), 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cnt = 0;
    repeat (30) begin step(); if (s_tick != 0 || s_clk != 0) cnt++; end
    chk("post_rst_quiet", 32'(cnt), 32'h0);

    // Random traffic against the model.
    do_reset();
    repeat (2000) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = 20'($urandom_range(0, 9));
      sync      = ($urandom_range(0, 40) == 0);
      step();
    end
    cfg_valid = 1'b0; sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
